// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse_gen block.
package pulse_pkg;

  localparam int unsigned PULSE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } pulse_state_e;

endpackage

// File: rtl/pulse_cnt.sv
// Loadable down-counter with a zero flag; it saturates at zero and never wraps.
module pulse_cnt
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = PULSE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable single-pulse generator (IDLE/HIGH/LOW/DONE).
// Define PULSE_GEN_BURST_EN to add the n_pulses input and repeat HIGH/LOW pairs.
module pulse_gen
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = PULSE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] high_len,
  input  logic [WIDTH-1:0] low_len,
`ifdef PULSE_GEN_BURST_EN
  input  logic [WIDTH-1:0] n_pulses,
`endif
  output logic             out,
  output logic             busy,
  output logic             done
);

  pulse_state_e     r_state;
  pulse_state_e     w_next;
  logic [WIDTH-1:0] r_low_len;
  logic             r_out;
  logic             w_load;
  logic             w_en;
  logic [WIDTH-1:0] w_load_val;
  logic             w_zero;
  logic             w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef PULSE_GEN_BURST_EN
  logic [WIDTH-1:0] r_high_len;
  logic [WIDTH-1:0] r_pulses_left;
  logic             w_more;

  assign w_more = (r_pulses_left > WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_len    <= '0;
      r_pulses_left <= '0;
    end else if (w_accept) begin
      r_high_len    <= high_len;
      r_pulses_left <= (n_pulses == '0) ? WIDTH'(1) : n_pulses;
    end else if ((r_state == ST_LOW) && (w_next == ST_HIGH)) begin
      r_pulses_left <= r_pulses_left - WIDTH'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_low_len <= '0;
      r_out     <= 1'b0;
    end else begin
      r_state <= w_next;
      // out is registered from the next state so it is high exactly while in HIGH
      r_out   <= (w_next == ST_HIGH);
      if (w_accept) begin
        r_low_len <= low_len;
      end
    end
  end

  // Phase counter is loaded with len-1 so the phase ends on the cycle it reads zero
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (high_len != '0) begin
            w_next     = ST_HIGH;
            w_load     = 1'b1;
            w_load_val = high_len - WIDTH'(1);
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        w_en = 1'b1;
        if (w_zero) begin
          if (r_low_len != '0) begin
            w_next     = ST_LOW;
            w_load     = 1'b1;
            w_load_val = r_low_len - WIDTH'(1);
          end
`ifdef PULSE_GEN_BURST_EN
          else if (w_more) begin
            w_next     = ST_LOW;
            w_load     = 1'b1;
            w_load_val = '0;
          end
`endif
          else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_LOW: begin
        w_en = 1'b1;
        if (w_zero) begin
`ifdef PULSE_GEN_BURST_EN
          if (w_more) begin
            w_next     = ST_HIGH;
            w_load     = 1'b1;
            w_load_val = r_high_len - WIDTH'(1);
          end else begin
            w_next = ST_DONE;
          end
`else
          w_next = ST_DONE;
`endif
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  pulse_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  assign out  = r_out;
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen; per-cycle traces are reduced to stats.
module tb_pulse_gen;

  localparam int unsigned W = 8;
  localparam int unsigned TMAX = 300;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
`ifdef PULSE_GEN_BURST_EN
  logic [W-1:0] n_pulses;
`endif
  logic         out;
  logic         busy;
  logic         done;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  bit out_tr  [TMAX];
  bit busy_tr [TMAX];
  bit done_tr [TMAX];

  int unsigned hi_cnt, hi_first, hi_last, done_cnt, done_idx, busy_cnt;
  int unsigned pulses, min_run, max_run;

  always #5 clk = ~clk;

  pulse_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .high_len (high_len),
    .low_len  (low_len),
`ifdef PULSE_GEN_BURST_EN
    .n_pulses (n_pulses),
`endif
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample index 0 is the cycle right after the edge that sees start.
  task automatic capture(input int unsigned n, input bit hold);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      if (i == 0 && !hold) start = 1'b0;
      out_tr[i]  = out;
      busy_tr[i] = busy;
      done_tr[i] = done;
    end
  endtask

  task automatic stats(input int unsigned n);
    int unsigned run;
    hi_cnt = 0; hi_first = 999; hi_last = 999; done_cnt = 0; done_idx = 999;
    busy_cnt = 0; pulses = 0; min_run = 999; max_run = 0; run = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (out_tr[i]) begin
        hi_cnt++;
        if (hi_first == 999) hi_first = i;
        hi_last = i;
        if (i == 0 || !out_tr[i-1]) pulses++;
        run++;
      end
      if (!out_tr[i] || i == n - 1) begin
        if (run > 0) begin
          if (run < min_run) min_run = run;
          if (run > max_run) max_run = run;
        end
        run = 0;
      end
      if (done_tr[i]) begin
        done_cnt++;
        if (done_idx == 999) done_idx = i;
      end
      if (busy_tr[i]) busy_cnt++;
    end
  endtask

  task automatic settle();
    start = 1'b0;
    for (int unsigned i = 0; i < 6; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; high_len = '0; low_len = '0;
`ifdef PULSE_GEN_BURST_EN
    n_pulses = '0;
`endif
    #1;
    check_val("rst_out", out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check_val("idle_busy", busy, 0);

    // 10 high, 5 low, done, busy 16
    high_len = 8'd10; low_len = 8'd5; start = 1'b1;
    capture(30, 1'b0);
    stats(30);
    check_val("t1_hi_cnt", hi_cnt, 10);
    check_val("t1_hi_first", hi_first, 0);
    check_val("t1_hi_last", hi_last, 9);
    check_val("t1_done_idx", done_idx, 15);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_busy_cnt", busy_cnt, 16);
    settle();

    // empty request
    high_len = 8'd0; low_len = 8'd5; start = 1'b1;
    capture(10, 1'b0);
    stats(10);
    check_val("t2_hi_cnt", hi_cnt, 0);
    check_val("t2_done_idx", done_idx, 0);
    check_val("t2_done_cnt", done_cnt, 1);
    check_val("t2_busy_cnt", busy_cnt, 1);
    settle();

    // start held, low_len=0: period HIGH x3, DONE, IDLE
    high_len = 8'd3; low_len = 8'd0; start = 1'b1;
    capture(20, 1'b1);
    stats(20);
    check_val("t3_pulses", pulses, 4);
    check_val("t3_min_run", min_run, 3);
    check_val("t3_max_run", max_run, 3);
    check_val("t3_done_cnt", done_cnt, 4);
    check_val("t3_gap_a", out_tr[3], 0);
    check_val("t3_gap_b", out_tr[4], 0);
    check_val("t3_next_hi", out_tr[5], 1);
    check_val("t3_done_pos", done_tr[3], 1);
    settle();

    // reset at the 7th high cycle
    high_len = 8'd20; low_len = 8'd5; start = 1'b1;
    capture(7, 1'b0);
    stats(7);
    check_val("t4_pre_hi", hi_cnt, 7);
    rst_n = 1'b0;
    #1;
    check_val("t4_rst_out", out, 0);
    check_val("t4_rst_busy", busy, 0);
    check_val("t4_rst_done", done, 0);
    step(); step();
    rst_n = 1'b1;
    high_len = 8'd4; low_len = 8'd0; start = 1'b1;
    capture(10, 1'b0);
    stats(10);
    check_val("t4_hi_cnt", hi_cnt, 4);
    check_val("t4_hi_first", hi_first, 0);
    check_val("t4_done_idx", done_idx, 4);
    settle();

    // lengths changed while busy are ignored
    high_len = 8'd8; low_len = 8'd2; start = 1'b1;
    step();
    start = 1'b0; high_len = 8'd2; low_len = 8'd7;
    out_tr[0] = out; busy_tr[0] = busy; done_tr[0] = done;
    for (int unsigned i = 1; i < 20; i++) begin
      step();
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      out_tr[i] = out; busy_tr[i] = busy; done_tr[i] = done;
    end
    stats(20);
    check_val("t5_hi_cnt", hi_cnt, 8);
    check_val("t5_done_idx", done_idx, 10);
    check_val("t5_done_cnt", done_cnt, 1);
    settle();

    // maximum length, no wrap
    high_len = 8'd255; low_len = 8'd1; start = 1'b1;
    capture(262, 1'b0);
    stats(262);
    check_val("t6_hi_cnt", hi_cnt, 255);
    check_val("t6_hi_last", hi_last, 254);
    check_val("t6_done_idx", done_idx, 256);
    settle();

`ifdef PULSE_GEN_BURST_EN
    begin
      logic [7:0] pat;
      n_pulses = 8'd3; high_len = 8'd2; low_len = 8'd0; start = 1'b1;
      capture(12, 1'b0);
      stats(12);
      pat = '0;
      for (int unsigned i = 0; i < 8; i++) pat[7-i] = out_tr[i];
      check_val("t7_pattern", pat, 8'b1101_1011);
      check_val("t7_done_idx", done_idx, 8);
      check_val("t7_done_cnt", done_cnt, 1);
      check_val("t7_hi_cnt", hi_cnt, 6);
      settle();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of all length/count inputs and internal counters.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a pulse sequence, sampled only in IDLE.
REQ-005 SHALL have port high_len  input  WIDTH  number of clk cycles out is held high per pulse.
REQ-006 SHALL have port low_len  input  WIDTH  number of clk cycles out is held low after each pulse.
REQ-007 SHALL have port out  output  1  generated pulse, registered.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  single-cycle completion strobe.

Function
REQ-010 SHALL implement states IDLE, HIGH, LOW, DONE.
REQ-011 SHALL, in IDLE with start=1 and high_len!=0, latch high_len and low_len and enter HIGH on the next edge.
REQ-012 SHALL hold out=1 for exactly high_len consecutive cycles in HIGH, so a pulse-width counter sampling out on clk measures exactly high_len.
REQ-013 SHALL go from HIGH to LOW when low_len!=0, and from HIGH directly to DONE when low_len=0.
REQ-014 SHALL hold out=0 for exactly low_len cycles in LOW, then enter DONE.
REQ-015 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-016 SHALL treat start in IDLE with high_len=0 as an empty request: no out pulse; go directly to DONE; one done strobe.
REQ-017 SHALL ignore start and changes on high_len/low_len while busy=1, using the latched values.
REQ-018 SHALL accept a new start in the IDLE cycle immediately following DONE, giving back-to-back sequences with a minimum one-cycle low gap between pulses.
REQ-019 SHALL use down-counters of WIDTH bits that never wrap: high_len=2^WIDTH-1 gives exactly 2^WIDTH-1 high cycles.
REQ-020 SHALL keep out=0 and done=0 in IDLE.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-pulse, immediately force state=IDLE, out=0, busy=0, done=0, and clear counters and latched lengths.
REQ-022 SHALL leave reset synchronously-safe: first start is accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL, when PULSE_GEN_BURST_EN is defined, add input n_pulses (WIDTH bits), latched at start, and repeat the HIGH/LOW pair n_pulses times before DONE; n_pulses=0 is treated as 1; done strobes once per burst.
REQ-024 SHALL, when PULSE_GEN_BURST_EN is defined and low_len=0, insert one forced low cycle between consecutive pulses of a burst so pulses stay distinguishable, with no extra low cycle after the last pulse.
REQ-025 SHALL, without PULSE_GEN_BURST_EN, have no n_pulses port and generate exactly one pulse per start.

Structure
REQ-026 SHALL take the state enum typedef and the default WIDTH constant from shared package pulse_pkg.
REQ-027 SHALL instantiate one sub-module, pulse_cnt, a loadable WIDTH-bit down-counter with load, enable, and zero-flag, used for both HIGH and LOW phases.

Verification
REQ-028 SHALL cover: high_len=10, low_len=5, start for 1 cycle -> out high for exactly 10 cycles, low 5, done one cycle, busy high for 16 cycles.
REQ-029 SHALL cover: high_len=0, start -> out never high; done asserted one cycle after start; busy high for 1 cycle.
REQ-030 SHALL cover: high_len=3, low_len=0, start held high continuously -> repeated 3-cycle pulses separated by exactly 2 low cycles (DONE, IDLE); one done per pulse.
REQ-031 SHALL cover: high_len=20, rst_n pulled low at the 7th high cycle -> out=0, busy=0 immediately; after release, a new start with high_len=4 gives a 4-cycle pulse.
REQ-032 SHALL cover: high_len=8, start, then high_len changed to 2 on the next cycle -> pulse still 8 cycles.
REQ-033 SHALL cover, with PULSE_GEN_BURST_EN: n_pulses=3, high_len=2, low_len=0 -> out pattern 11011011 followed by a single done strobe.
